// File: rtl/cpu16_pkg.sv
// Shared definitions for the CPU16 program loader.
//   SYNC_BYTE      : frame start marker (0xA5)
//   WORD_W         : program word width (16)
//   loaderState_t  : loader frame FSM states
//   rxState_t      : serial receiver FSM states
//   csumAdd        : mod-256 checksum accumulate helper
package cpu16_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         WORD_W    = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CSUM    = 3'd5,
        ERROR   = 3'd6
    } loaderState_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rxState_t;

    // Mod-256 running sum; the carry out is intentionally dropped.
    function automatic logic [7:0] csumAdd(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Program-memory write bus and loader status.
//   writeEn/writeAddr/writeData : one-cycle program word write
//   cpuHold                     : keep CPU in reset
//   loadDone                    : one-cycle frame-complete pulse
//   loadError                   : sticky failure flag
// Modports: master (loader drives), slave (memory/CPU side observes).
interface rom_loader_if
    import cpu16_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              writeEn;
    logic [ADDR_W-1:0] writeAddr;
    logic [WORD_W-1:0] writeData;
    logic              cpuHold;
    logic              loadDone;
    logic              loadError;

    modport master (output writeEn, writeAddr, writeData, cpuHold, loadDone, loadError);
    modport slave  (input  writeEn, writeAddr, writeData, cpuHold, loadDone, loadError);
endinterface

// File: rtl/rom_loader_uart_rx.sv
// uart_rx: 8N1 serial byte receiver.
//   clk, rstN : clock, async active-low reset
//   rx        : asynchronous serial input, idle high
//   byteValid : one-cycle strobe, byteData holds the received byte
//   byteData  : received byte (LSB first on the line)
//   frameErr  : one-cycle strobe when a stop bit is sampled low
module uart_rx
    import cpu16_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       rx,
    output logic       byteValid,
    output logic [7:0] byteData,
    output logic       frameErr
);
    localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic          rxMeta_r, rxSync_r, rxPrev_r;
    rxState_t      state_r, stateNext;
    logic [CW-1:0] cnt_r, cntNext;
    logic [2:0]    bitIdx_r, bitIdxNext;
    logic [7:0]    shift_r, shiftNext;
    logic          byteValid_r, byteValidNext;
    logic          frameErr_r, frameErrNext;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rxMeta_r <= 1'b1;
            rxSync_r <= 1'b1;
            rxPrev_r <= 1'b1;
        end else begin
            rxMeta_r <= rx;
            rxSync_r <= rxMeta_r;
            rxPrev_r <= rxSync_r;
        end
    end

    // Receiver state, bit timing and shift register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r     <= RX_IDLE;
            cnt_r       <= '0;
            bitIdx_r    <= 3'd0;
            shift_r     <= 8'h00;
            byteValid_r <= 1'b0;
            frameErr_r  <= 1'b0;
        end else begin
            state_r     <= stateNext;
            cnt_r       <= cntNext;
            bitIdx_r    <= bitIdxNext;
            shift_r     <= shiftNext;
            byteValid_r <= byteValidNext;
            frameErr_r  <= frameErrNext;
        end
    end

    // Next-state: confirm start at half a bit, then sample each bit centre.
    always_comb begin
        stateNext     = state_r;
        cntNext       = cnt_r + CW'(1);
        bitIdxNext    = bitIdx_r;
        shiftNext     = shift_r;
        byteValidNext = 1'b0;
        frameErrNext  = 1'b0;
        case (state_r)
            RX_IDLE: begin
                cntNext = '0;
                if (rxPrev_r && !rxSync_r) begin
                    stateNext = RX_START;
                end else begin
                    stateNext = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r == HALF_LAST) begin
                    cntNext    = '0;
                    bitIdxNext = 3'd0;
                    // A line back high at mid-start was a glitch: drop it.
                    stateNext  = rxSync_r ? RX_IDLE : RX_DATA;
                end else begin
                    stateNext = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cntNext    = '0;
                    shiftNext  = {rxSync_r, shift_r[7:1]};
                    bitIdxNext = bitIdx_r + 3'd1;
                    stateNext  = (bitIdx_r == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    stateNext = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cntNext       = '0;
                    stateNext     = RX_IDLE;
                    byteValidNext = rxSync_r;
                    frameErrNext  = !rxSync_r;
                end else begin
                    stateNext = RX_STOP;
                end
            end
            default: begin
                stateNext = RX_IDLE;
                cntNext   = '0;
            end
        endcase
    end

    assign byteValid = byteValid_r;
    assign byteData  = shift_r;
    assign frameErr  = frameErr_r;
endmodule

// File: rtl/rom_loader.sv
// rom_loader: receives a program image over a serial line and writes it
// into program memory while holding the CPU in reset.
//   clk, rstN : clock, async active-low reset
//   rx        : serial input, 8N1 idle high
//   bus       : write bus and status (writeEn, writeAddr, writeData,
//               cpuHold, loadDone, loadError)
// Frame: A5, len hi, len lo, N words (high byte first) [, checksum].
// Build option: define ROM_LOADER_CHECKSUM_EN to expect and verify a
// trailing checksum byte; otherwise the frame ends after the last word.
module rom_loader
    import cpu16_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 868,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          rx,
    rom_loader_if.master  bus
);
    // Word counter must hold N up to 65535 and the limit 2^ADDR_W.
    localparam int               CNT_W     = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;
    localparam int               TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic       byteValid, frameErr;
    logic [7:0] byteData;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uRx (
        .clk       (clk),
        .rstN      (rstN),
        .rx        (rx),
        .byteValid (byteValid),
        .byteData  (byteData),
        .frameErr  (frameErr)
    );

    loaderState_t      state_r, stateNext;
    logic              writeEn_r, writeEnNext;
    logic [ADDR_W-1:0] writeAddr_r, writeAddrNext;
    logic [WORD_W-1:0] writeData_r, writeDataNext;
    logic              cpuHold_r, cpuHoldNext;
    logic              loadDone_r, loadDoneNext;
    logic              loadError_r, loadErrorNext;
    logic [7:0]        lenHi_r, lenHiNext;
    logic [7:0]        dataHi_r, dataHiNext;
    logic [CNT_W-1:0]  wordsLeft_r, wordsLeftNext;
    logic [TW-1:0]     idleCnt_r, idleCntNext;
    logic [CNT_W-1:0]  lenWords_s;
    logic              inFrame_s, timedOut_s, finish_s, badFrame_s;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]        acc_r, accNext;
`endif

    assign lenWords_s = CNT_W'({lenHi_r, byteData});
    assign inFrame_s  = (state_r != IDLE) && (state_r != ERROR);
    assign timedOut_s = inFrame_s && !byteValid && (idleCnt_r == TMO_LAST);

    // Loader state and registered outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r     <= IDLE;
            writeEn_r   <= 1'b0;
            writeAddr_r <= '0;
            writeData_r <= '0;
            cpuHold_r   <= 1'b0;
            loadDone_r  <= 1'b0;
            loadError_r <= 1'b0;
            lenHi_r     <= 8'h00;
            dataHi_r    <= 8'h00;
            wordsLeft_r <= '0;
            idleCnt_r   <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            acc_r       <= 8'h00;
`endif
        end else begin
            state_r     <= stateNext;
            writeEn_r   <= writeEnNext;
            writeAddr_r <= writeAddrNext;
            writeData_r <= writeDataNext;
            cpuHold_r   <= cpuHoldNext;
            loadDone_r  <= loadDoneNext;
            loadError_r <= loadErrorNext;
            lenHi_r     <= lenHiNext;
            dataHi_r    <= dataHiNext;
            wordsLeft_r <= wordsLeftNext;
            idleCnt_r   <= idleCntNext;
`ifdef ROM_LOADER_CHECKSUM_EN
            acc_r       <= accNext;
`endif
        end
    end

    // Frame parsing, word writes, completion and error handling.
    always_comb begin
        stateNext     = state_r;
        writeEnNext   = 1'b0;
        loadDoneNext  = 1'b0;
        // The address steps in the cycle after each write strobe.
        writeAddrNext = writeEn_r ? (writeAddr_r + ADDR_W'(1)) : writeAddr_r;
        writeDataNext = writeData_r;
        cpuHoldNext   = cpuHold_r;
        loadErrorNext = loadError_r;
        lenHiNext     = lenHi_r;
        dataHiNext    = dataHi_r;
        wordsLeftNext = wordsLeft_r;
        finish_s      = 1'b0;
        badFrame_s    = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
        accNext       = acc_r;
`endif
        if (inFrame_s && !byteValid) begin
            idleCntNext = idleCnt_r + TW'(1);
        end else begin
            idleCntNext = '0;
        end

        case (state_r)
            IDLE, ERROR: begin
                if (byteValid && (byteData == SYNC_BYTE)) begin
                    stateNext     = LEN_HI;
                    loadErrorNext = 1'b0;
                    cpuHoldNext   = 1'b1;
                    writeAddrNext = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                    accNext       = 8'h00;
`endif
                end else begin
                    stateNext = state_r;
                end
            end
            LEN_HI: begin
                if (byteValid) begin
                    lenHiNext = byteData;
                    stateNext = LEN_LO;
`ifdef ROM_LOADER_CHECKSUM_EN
                    accNext   = csumAdd(acc_r, byteData);
`endif
                end else begin
                    stateNext = LEN_HI;
                end
            end
            LEN_LO: begin
                if (byteValid) begin
                    wordsLeftNext = lenWords_s;
`ifdef ROM_LOADER_CHECKSUM_EN
                    accNext       = csumAdd(acc_r, byteData);
`endif
                    if (lenWords_s == '0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        stateNext = CSUM;
`else
                        finish_s  = 1'b1;
`endif
                    end else if (lenWords_s > MAX_WORDS) begin
                        badFrame_s = 1'b1;
                    end else begin
                        stateNext = DATA_HI;
                    end
                end else begin
                    stateNext = LEN_LO;
                end
            end
            DATA_HI: begin
                if (byteValid) begin
                    dataHiNext = byteData;
                    stateNext  = DATA_LO;
`ifdef ROM_LOADER_CHECKSUM_EN
                    accNext    = csumAdd(acc_r, byteData);
`endif
                end else begin
                    stateNext = DATA_HI;
                end
            end
            DATA_LO: begin
                if (byteValid) begin
                    writeEnNext   = 1'b1;
                    writeDataNext = {dataHi_r, byteData};
                    wordsLeftNext = wordsLeft_r - CNT_W'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
                    accNext       = csumAdd(acc_r, byteData);
`endif
                    if (wordsLeft_r == CNT_W'(1)) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        stateNext = CSUM;
`else
                        finish_s  = 1'b1;
`endif
                    end else begin
                        stateNext = DATA_HI;
                    end
                end else begin
                    stateNext = DATA_LO;
                end
            end
            CSUM: begin
`ifdef ROM_LOADER_CHECKSUM_EN
                if (byteValid) begin
                    finish_s   = (csumAdd(acc_r, byteData) == 8'h00);
                    badFrame_s = (csumAdd(acc_r, byteData) != 8'h00);
                end else begin
                    stateNext = CSUM;
                end
`else
                stateNext = IDLE;
`endif
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Errors override any progress made this cycle.
        if (frameErr || timedOut_s || badFrame_s) begin
            stateNext     = ERROR;
            loadErrorNext = 1'b1;
            cpuHoldNext   = 1'b1;
        end else if (finish_s) begin
            stateNext    = IDLE;
            loadDoneNext = 1'b1;
            cpuHoldNext  = 1'b0;
        end else begin
            loadDoneNext = 1'b0;
        end
    end

    assign bus.writeEn   = writeEn_r;
    assign bus.writeAddr = writeAddr_r;
    assign bus.writeData = writeData_r;
    assign bus.cpuHold   = cpuHold_r;
    assign bus.loadDone  = loadDone_r;
    assign bus.loadError = loadError_r;
endmodule
